// File: rtl/score_display.sv
// Binary score -> 4-digit multiplexed seven-segment display with leading-zero blanking.
// A new value takes 15 cycles to reach the display registers; changes that arrive mid-conversion are deferred.
module score_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        overflow,
    output logic        busy
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   last_val_q, last_val_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d, bcd_adj;
    logic [3:0]    cnt_q, cnt_d;
    logic          ovf_cap_q, ovf_cap_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   disp_bcd_q, disp_bcd_d;

    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction applied before each shift of the double-dabble engine.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_cap_d  = ovf_cap_q;
        busy_d     = busy_q;
        overflow_d = overflow_q;
        disp_bcd_d = disp_bcd_q;
        case (state_q)
            IDLE: begin
                if (value != last_val_q) begin
                    last_val_d = value;
                    if (value > 32'd9999) begin
                        bin_d     = 14'd9999;
                        ovf_cap_d = 1'b1;
                    end else begin
                        bin_d     = value[13:0];
                        ovf_cap_d = 1'b0;
                    end
                    bcd_d   = 16'h0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_bcd_d = bcd_q;
                overflow_d = ovf_cap_q;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A digit above the units is blanked when it and every digit above it are zero.
    always_comb begin
        ref_cnt_d = (ref_cnt_q == REF_MAX) ? '0 : ref_cnt_q + 1'b1;
        dig_d     = (ref_cnt_q == REF_MAX) ? dig_q + 2'd1 : dig_q;
        nib       = disp_bcd_q[{dig_q, 2'b00} +: 4];
        blank     = (dig_q != 2'd0) && ((disp_bcd_q >> {dig_q, 2'b00}) == 16'd0);
        an_d      = ~(4'b0001 << dig_q);
        seg_d     = blank ? 7'b1111111 : seg_decode(nib);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_val_q <= 32'd0;
            bin_q      <= 14'd0;
            bcd_q      <= 16'd0;
            cnt_q      <= 4'd0;
            ovf_cap_q  <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            disp_bcd_q <= 16'd0;
            ref_cnt_q  <= '0;
            dig_q      <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_cap_q  <= ovf_cap_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            disp_bcd_q <= disp_bcd_d;
            ref_cnt_q  <= ref_cnt_d;
            dig_q      <= dig_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = 1'b1;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: expected displays are queued at stimulus time, a monitor checks every cycle.
module tb_score_display;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] value = 32'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        overflow;
    logic        busy;

    always #5 clk = ~clk;

    score_display #(.REFRESH_DIV(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .overflow (overflow),
        .busy     (busy)
    );

    typedef struct packed {
        logic            ovf;
        logic [3:0][6:0] s;
    } exp_t;

    const logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];
    exp_t cur;
    int   pushed_total = 0;
    int   conv_total = 0;
    int   rel_edges = 0;
    logic [31:0] last_issued = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // Display expected for a score: saturate, split into decimal digits, blank leading zeros.
    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        int   shown;
        int   div;
        e.ovf = (v > 32'd9999);
        shown = e.ovf ? 9999 : int'(v);
        div   = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0 && shown < div) e.s[k] = 7'b1111111;
            else                      e.s[k] = seg_tab[(shown / div) % 10];
            div = div * 10;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) rel_edges <= 0;
        else      rel_edges <= rel_edges + 1;
    end

    initial begin
        int       d;
        int       busy_run;
        logic     busy_prev;
        logic [3:0] an_exp;
        cur       = model(32'd0);
        busy_run  = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst || rel_edges == 0) begin
                chk("rst_an", an, 32'hF);
                chk("rst_seg", seg, 32'h7F);
                chk("rst_dp", dp, 1);
                chk("rst_overflow", overflow, 0);
                chk("rst_busy", busy, 0);
                cur        = model(32'd0);
                busy_run   = 0;
                busy_prev  = 1'b0;
                conv_total = 0;
            end else begin
                d      = ((rel_edges - 1) / R) % 4;
                an_exp = ~(4'b0001 << d);
                chk("an_scan", an, an_exp);
                chk("dp", dp, 1);
                chk($sformatf("seg_digit%0d", d), seg, cur.s[d]);
                if (busy && !busy_prev) conv_total++;
                if (busy) busy_run++;
                if (!busy && busy_prev) begin
                    chk("busy_len", busy_run, 15);
                    busy_run = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_conversion: got a completed conversion expected none at %0t", $time);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                chk("overflow", overflow, cur.ovf);
                busy_prev = busy;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] v);
        value = v;
        if (v != last_issued) begin
            exp_q.push_back(model(v));
            pushed_total++;
        end
        last_issued = v;
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 6 && !busy; i++) @(negedge clk);
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_quiet();
        int quiet = 0;
        int n = 0;
        while (quiet < 20 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            quiet = busy ? 0 : quiet + 1;
        end
        chk("settle", (quiet >= 20), 1);
        chk("conv_count", conv_total, pushed_total);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 9));
            1:       return 32'($urandom_range(0, 9999));
            2:       return $urandom;
            default: return 32'($urandom_range(9990, 10010));
        endcase
    endfunction

    initial begin
        logic [31:0] v1;
        tick(3);
        rst = 1'b1;
        wait_quiet();

        issue(32'd1234);  wait_quiet();
        issue(32'd10000); wait_quiet();
        issue(32'd5);     wait_quiet();

        issue(32'd7); wait_busy(); tick(3); issue(32'd4321); wait_quiet();

        issue(32'd9999); wait_busy(); tick(5);
        rst = 1'b0;
        exp_q.delete();
        pushed_total = 0;
        #1;
        chk("abort_an", an, 32'hF);
        chk("abort_seg", seg, 32'h7F);
        chk("abort_busy", busy, 0);
        chk("abort_overflow", overflow, 0);
        tick(3);
        rst = 1'b1;
        exp_q.push_back(model(32'd9999));
        pushed_total++;
        wait_quiet();

        issue(32'd105); wait_quiet();
        issue(32'd0);   wait_quiet();

        for (int t = 0; t < 40; t++) begin
            v1 = pick();
            while (v1 == last_issued) v1 = pick();
            issue(v1);
            if ($urandom_range(0, 1) == 1) begin
                wait_busy();
                tick($urandom_range(0, 15));
                issue(pick());
            end
            wait_quiet();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d checks so far", checks);
        $fatal(1);
    end

endmodule
